// File: rtl/dct_mac_accum.sv
// dct_mac_accum: multiply-accumulate stage of the fdct DCT unit.
// Each enabled cycle presents one term (din * coef). Terms flow through a
// three-stage pipeline: input register, product register, then an accumulator FSM.
// That FSM sums TERMS products into one DCT coefficient.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   ena        global advance; each enabled cycle presents one term
//   dclr       current term is the first term of a new coefficient
//   din        signed sample
//   coef       signed cosine coefficient
//   result     signed accumulated coefficient, held until next completion
//   res_valid  one-clk pulse when result is updated
//   ovf_err    sticky: a term arrived after TERMS terms without dclr
module dct_mac_accum #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned CWIDTH = 16,
  parameter int unsigned TERMS  = 8,
  localparam int unsigned MWIDTH = DWIDTH + CWIDTH,
  localparam int unsigned RWIDTH = MWIDTH + $clog2(TERMS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     dclr,
  input  logic signed [DWIDTH-1:0] din,
  input  logic signed [CWIDTH-1:0] coef,
  output logic signed [RWIDTH-1:0] result,
  output logic                     res_valid,
  output logic                     ovf_err
);

  // One extra bit so the counter can hold TERMS itself.
  localparam int unsigned CntW = $clog2(TERMS) + 1;

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  // S1
  logic signed [DWIDTH-1:0] din_q;
  logic signed [CWIDTH-1:0] coef_q;
  logic                     dclr_q;
  logic                     v1_q;
  // S2
  logic signed [MWIDTH-1:0] mult_res;
  logic                     dclr_qq;
  logic                     v2_q;
  // S3
  state_e                   state_q;
  logic signed [RWIDTH-1:0] acc_q;
  logic [CntW-1:0]          cnt_q;

  logic signed [RWIDTH-1:0] mult_ext;
  logic signed [RWIDTH-1:0] acc_sum;
  logic [CntW-1:0]          cnt_inc;
  logic                     term_s3;

  assign mult_ext = {{(RWIDTH - MWIDTH){mult_res[MWIDTH-1]}}, mult_res};
  assign acc_sum  = acc_q + mult_ext;
  assign cnt_inc  = cnt_q + 1'b1;
  assign term_s3  = ena & v2_q;

  // Input and product stages; both hold whenever ena is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_q    <= '0;
      coef_q   <= '0;
      dclr_q   <= 1'b0;
      v1_q     <= 1'b0;
      mult_res <= '0;
      dclr_qq  <= 1'b0;
      v2_q     <= 1'b0;
    end else if (ena) begin
      din_q    <= din;
      coef_q   <= coef;
      dclr_q   <= dclr;
      v1_q     <= 1'b1;
      mult_res <= MWIDTH'(din_q) * MWIDTH'(coef_q);
      dclr_qq  <= dclr_q;
      v2_q     <= v1_q;
    end
  end

  // Accumulator FSM. res_valid drops on every edge, enabled or not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      result    <= '0;
      res_valid <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (term_s3) begin
        if (dclr_qq) begin
          // A new coefficient starts from any state; a partial sum is dropped.
          acc_q   <= mult_ext;
          cnt_q   <= CntW'(1);
          ovf_err <= 1'b0;
          state_q <= StAcc;
        end else begin
          unique case (state_q)
            StIdle: begin
              // Terms before the first dclr are discarded.
            end
            StAcc: begin
              acc_q <= acc_sum;
              cnt_q <= cnt_inc;
              if (cnt_inc == CntW'(TERMS)) begin
                result    <= acc_sum;
                res_valid <= 1'b1;
                state_q   <= StDone;
              end
            end
            StDone: begin
              ovf_err <= 1'b1;
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

endmodule
